// File: rtl/zigbee_pkg.sv
// Shared constants, state type and the 16x32 symbol-to-chip table for the
// O-QPSK DSSS transmit path.
package zigbee_pkg;

  localparam int SYMBOL_W         = 4;
  localparam int CHIPS_PER_SYMBOL = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    SPREAD = 1'b1
  } spread_state_t;

  // Symbol 0 written c0 first: index 0 of this ascending vector is c0.
  localparam logic [0:31] SYM0_CHIPS = 32'b11011001110000110101001000101110;

  // Symbols 1..7 rotate symbol 0 by 4 chips each; 8..15 also flip odd chips.
  function automatic logic [15:0][31:0] buildChipTable();
    logic [15:0][31:0] t;
    int src;
    t = '0;
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 32; i++) begin
        src     = (i + 32 - 4 * (s % 8)) % 32;
        t[s][i] = SYM0_CHIPS[src] ^ ((s >= 8) && (i % 2 == 1));
      end
    end
    return t;
  endfunction

  localparam logic [15:0][31:0] CHIP_TABLE = buildChipTable();

endpackage

// File: rtl/chip_spreader_if.sv
// Symbol handshake and serial chip outputs of the spreader.
// Handshake: a symbol moves on a rising edge where inValid && outReady are
// both high; outReady never depends on inValid and inValid may be raised at any time.
interface chip_spreader_if;
  import zigbee_pkg::*;

  logic [SYMBOL_W-1:0] inSymbol;
  logic                inValid;
  logic                outReady;
  logic                outChip;
  logic                outSel;
  logic                outChipValid;
  logic                outSymDone;
  logic                outBusy;
  spread_state_t       dbgState;

  modport master (
    output inSymbol, inValid,
    input  outReady, outChip, outSel, outChipValid, outSymDone, outBusy, dbgState
  );

  modport slave (
    input  inSymbol, inValid,
    output outReady, outChip, outSel, outChipValid, outSymDone, outBusy, dbgState
  );
endinterface

// File: rtl/chip_tick_gen.sv
// Chip-period divider: reports the last cycle of the current chip plus
// first/last strobes for the next cycle, so callers can register outputs.
module chip_tick_gen #(
  parameter int CLK_PER_CHIP = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  output logic chipLast,
  output logic firstNext,
  output logic lastNext
);
  localparam int DIV_W = (CLK_PER_CHIP > 1) ? $clog2(CLK_PER_CHIP) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_CHIP - 1);

  logic [DIV_W-1:0] div, divNext;

  assign chipLast  = (div == DIV_MAX);
  assign divNext   = (clear || chipLast) ? '0 : div + DIV_W'(1);
  assign firstNext = (divNext == '0);
  assign lastNext  = (divNext == DIV_MAX);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) div <= '0;
    else       div <= divNext;
  end
endmodule

// File: rtl/chip_spreader.sv
// Symbol-to-chip DSSS spreader: takes 4-bit symbols and emits their 32-chip
// PN sequence serially, back-to-back with no idle gap.
module chip_spreader
  import zigbee_pkg::*;
#(
  parameter int CLK_PER_CHIP = 4
) (
  input logic            inClk,
  input logic            inRstN,
  chip_spreader_if.slave bus
);
  localparam int IDX_W = $clog2(CHIPS_PER_SYMBOL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHIPS_PER_SYMBOL - 1);

  spread_state_t       state, stateNext;
  logic [SYMBOL_W-1:0] sym, symNext;
  logic [IDX_W-1:0]    idx, idxNext;
  logic                clear, chipLast, firstNext, lastNext;
  logic                transfer, spreadNext;
  logic                chipQ, selQ, chipValidQ, symDoneQ, busyQ;

  chip_tick_gen #(.CLK_PER_CHIP(CLK_PER_CHIP)) tickGen (
    .clk      (inClk),
    .rstN     (inRstN),
    .clear    (clear),
    .chipLast (chipLast),
    .firstNext(firstNext),
    .lastNext (lastNext)
  );

  assign bus.outReady = (state == IDLE) || ((idx == LAST_IDX) && chipLast);
  assign transfer     = bus.inValid && bus.outReady;
  assign spreadNext   = (stateNext == SPREAD);

  always_comb begin
    stateNext = state;
    symNext   = sym;
    idxNext   = idx;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        clear = 1'b1;
        if (transfer) begin
          stateNext = SPREAD;
          symNext   = bus.inSymbol;
          idxNext   = '0;
        end
      end
      SPREAD: begin
        if (chipLast) begin
          if (idx == LAST_IDX) begin
            clear   = 1'b1;
            idxNext = '0;
            if (transfer) symNext   = bus.inSymbol;
            else          stateNext = IDLE;
          end else begin
            idxNext = idx + IDX_W'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state      <= IDLE;
      sym        <= '0;
      idx        <= '0;
      chipQ      <= 1'b0;
      selQ       <= 1'b0;
      chipValidQ <= 1'b0;
      symDoneQ   <= 1'b0;
      busyQ      <= 1'b0;
    end else begin
      state      <= stateNext;
      sym        <= symNext;
      idx        <= idxNext;
      chipQ      <= spreadNext && CHIP_TABLE[symNext][idxNext];
      selQ       <= spreadNext && idxNext[0];
      chipValidQ <= spreadNext && firstNext;
      symDoneQ   <= spreadNext && (idxNext == LAST_IDX) && lastNext;
      busyQ      <= spreadNext;
    end
  end

  assign bus.outChip      = chipQ;
  assign bus.outSel       = selQ;
  assign bus.outChipValid = chipValidQ;
  assign bus.outSymDone   = symDoneQ;
  assign bus.outBusy      = busyQ;
  assign bus.dbgState     = state;
endmodule

// File: tb/tb_chip_spreader.sv
// Directed bench for chip_spreader: one instance at 4 clocks/chip, one at
// 1 clock/chip, with hand-written chip sequences as the reference.
module tb_chip_spreader;
  import zigbee_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN4, rstN1;
  always #5 clk = ~clk;

  chip_spreader_if bus4();
  chip_spreader_if bus1();

  logic       tbValid;
  logic       useOne;
  logic [3:0] tbSymbol;

  assign bus4.inValid  = tbValid && !useOne;
  assign bus1.inValid  = tbValid && useOne;
  assign bus4.inSymbol = tbSymbol;
  assign bus1.inSymbol = tbSymbol;

  chip_spreader #(.CLK_PER_CHIP(4)) dut4 (.inClk(clk), .inRstN(rstN4), .bus(bus4));
  chip_spreader #(.CLK_PER_CHIP(1)) dut1 (.inClk(clk), .inRstN(rstN1), .bus(bus1));

  // Observed vector of the selected instance: {ready, chip, sel, cv, done, busy}.
  logic [5:0]    mObs;
  spread_state_t mState;
  assign mObs = useOne ?
    {bus1.outReady, bus1.outChip, bus1.outSel, bus1.outChipValid, bus1.outSymDone, bus1.outBusy} :
    {bus4.outReady, bus4.outChip, bus4.outSel, bus4.outChipValid, bus4.outSymDone, bus4.outBusy};
  assign mState = useOne ? bus1.dbgState : bus4.dbgState;

  // Hand-derived sequences, c0 at index 0.
  localparam logic [0:31] EXP0  = 32'b11011001110000110101001000101110;
  localparam logic [0:31] EXP1  = 32'b11101101100111000011010100100010;
  localparam logic [0:31] EXP2  = 32'b00101110110110011100001101010010;
  localparam logic [0:31] EXP3  = 32'b00100010111011011001110000110101;
  localparam logic [0:31] EXP4  = 32'b01010010001011101101100111000011;
  localparam logic [0:31] EXP5  = 32'b00110101001000101110110110011100;
  localparam logic [0:31] EXP7  = 32'b10011100001101010010001011101101;
  localparam logic [0:31] EXP8  = 32'b10001100100101100000011101111011;
  localparam logic [0:31] EXP15 = 32'b11001001011000000111011110111000;

  int errors = 0;
  int checks = 0;
  int strobeCnt;
  int readyCnt;
  logic [5:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] s);
    int waited;
    tbSymbol = s;
    tbValid  = 1'b1;
    waited   = 0;
    while (!mObs[5] && waited < 300) begin
      step();
      waited++;
    end
    checks++;
    if (mObs[5] !== 1'b1) begin
      errors++;
      $display("FAIL send_ready sym %0d: ready=%b required 1 within 300 cycles", s, mObs[5]);
    end
    step();
    tbValid = 1'b0;
  endtask

  // Scoreboard fill: one expected output vector per cycle of a symbol.
  task automatic load_expected(input logic [0:31] exp);
    int  cpc;
    logic last;
    cpc = useOne ? 1 : 4;
    for (int i = 0; i < 32; i++) begin
      for (int d = 0; d < cpc; d++) begin
        last = (i == 31) && (d == cpc - 1);
        exp_q.push_back({last, exp[i], 1'(i % 2), (d == 0), last, 1'b1});
      end
    end
  endtask

  task automatic drain_expected(input string name);
    logic [5:0] want;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (mObs !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: {rdy,chip,sel,cv,done,busy}=%b required %b", name, n, mObs, want);
      end
      if (mObs[2]) strobeCnt++;
      if (mObs[5]) readyCnt++;
      n++;
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tbValid  = 1'b0;
    tbSymbol = 4'd0;
    useOne   = 1'b0;
    rstN4    = 1'b0;
    rstN1    = 1'b0;
    #1;
    checks++;
    if (mObs !== 6'b100000 || mState !== IDLE) begin
      errors++;
      $display("FAIL reset_cpc4: obs=%b state=%0d required 100000 state 0", mObs, mState);
    end
    useOne = 1'b1;
    #1;
    checks++;
    if (mObs !== 6'b100000 || mState !== IDLE) begin
      errors++;
      $display("FAIL reset_cpc1: obs=%b state=%0d required 100000 state 0", mObs, mState);
    end
    step();
    step();
    rstN4  = 1'b1;
    rstN1  = 1'b1;
    useOne = 1'b0;
    step();
  endtask

  task automatic test_symbol0();
    send(4'd0);
    load_expected(EXP0);
    drain_expected("sym0");
    checks++;
    if (mObs !== 6'b100000) begin
      errors++;
      $display("FAIL sym0_idle_after: obs=%b required 100000", mObs);
    end
  endtask

  task automatic test_back_to_back();
    strobeCnt = 0;
    readyCnt  = 0;
    tbSymbol  = 4'd3;
    tbValid   = 1'b1;
    step();
    tbSymbol = 4'd4;
    load_expected(EXP3);
    drain_expected("b2b_sym3");
    tbSymbol = 4'd5;
    load_expected(EXP4);
    drain_expected("b2b_sym4");
    tbValid = 1'b0;
    load_expected(EXP5);
    drain_expected("b2b_sym5");
    checks++;
    if (strobeCnt !== 96) begin
      errors++;
      $display("FAIL b2b_strobes: count=%0d required 96", strobeCnt);
    end
    checks++;
    if (readyCnt !== 3) begin
      errors++;
      $display("FAIL b2b_ready_cycles: count=%0d required 3", readyCnt);
    end
    checks++;
    if (mObs !== 6'b100000) begin
      errors++;
      $display("FAIL b2b_idle_after: obs=%b required 100000", mObs);
    end
  endtask

  task automatic test_cpc1();
    useOne = 1'b1;
    #1;
    send(4'd15);
    load_expected(EXP15);
    drain_expected("cpc1_sym15");
    checks++;
    if (mObs !== 6'b100000 || mState !== IDLE) begin
      errors++;
      $display("FAIL cpc1_idle_after: obs=%b state=%0d required 100000 state 0", mObs, mState);
    end
    useOne = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    logic doneSeen;
    doneSeen = 1'b0;
    send(4'd7);
    for (int c = 0; c < 40; c++) begin
      if (mObs[1]) doneSeen = 1'b1;
      step();
    end
    checks++;
    if (mObs !== {1'b0, EXP7[10], 1'b0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_chip10: obs=%b required %b", mObs, {1'b0, EXP7[10], 1'b0, 1'b1, 1'b0, 1'b1});
    end
    rstN4 = 1'b0;
    #1;
    checks++;
    if (mObs !== 6'b100000 || mState !== IDLE) begin
      errors++;
      $display("FAIL mid_reset_now: obs=%b state=%0d required 100000 state 0", mObs, mState);
    end
    for (int c = 0; c < 4; c++) begin
      if (mObs[1]) doneSeen = 1'b1;
      step();
    end
    checks++;
    if (doneSeen !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: done seen=%b required 0", doneSeen);
    end
    rstN4 = 1'b1;
    step();
    send(4'd2);
    load_expected(EXP2);
    drain_expected("after_reset_sym2");
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (mObs !== 6'b100000) begin
        errors++;
        $display("FAIL stall_idle cycle %0d: obs=%b required 100000", c, mObs);
      end
      step();
    end
    send(4'd1);
    load_expected(EXP1);
    drain_expected("stall_sym1");
    send(4'd8);
    load_expected(EXP8);
    drain_expected("sym8");
    checks++;
    if (mObs !== 6'b100000) begin
      errors++;
      $display("FAIL sym8_idle_after: obs=%b required 100000", mObs);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_symbol0();
    test_back_to_back();
    test_cpc1();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
